// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, the NOP encoding and the
// instruction-memory responder state type.
package cpu_pkg;
    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_t;
endpackage

// File: rtl/imem_array.sv
// DEPTH x 16 instruction RAM: one write port, one synchronous read port.
// A read and a write to the same word in one cycle return the old word.
module imem_array
    import cpu_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [INSTR_W-1:0]       wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [INSTR_W-1:0]       rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        // rdata holds between reads so the responder can present it until the next fetch
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder: accepts one fetch at a time,
// waits WAIT_STATES cycles, then pulses valid with the word (or NOP + err).
module imem_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic [15:0]              addr,
    output logic                     busy,
    output logic                     valid,
    output logic [INSTR_W-1:0]       instr,
    output logic                     err,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [INSTR_W-1:0]       prog_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [16:0] DEPTH_X   = 17'(DEPTH);
    localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    imem_state_t        state, state_next;
    logic [2:0]         cnt, cnt_next;
    logic [15:0]        addr_q;
    logic [15:0]        fetch_addr;
    logic               oor;
    logic               rd_en;
    logic               nop_q;
    logic [INSTR_W-1:0] rdata;

    // With zero wait states the read happens on the accepting edge, before
    // addr_q is loaded, so the live address is used while still in IDLE.
    assign fetch_addr = (state == IDLE) ? addr : addr_q;
    assign oor        = {1'b0, fetch_addr} >= DEPTH_X;
    assign rd_en      = (state_next == RESP) && !reset;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            addr_q <= 16'h0000;
            nop_q  <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && req) begin
                addr_q <= addr;
            end
            if (rd_en) begin
                nop_q <= oor;
            end
        end
    end

    imem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (rd_en),
        .raddr (fetch_addr[AW-1:0]),
        .rdata (rdata)
    );

    assign busy  = (state != IDLE);
    assign valid = (state == RESP);
    assign err   = (state == RESP) && nop_q;
    assign instr = nop_q ? NOP_INSTR : rdata;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances (0, 1 and 3 wait states)
// share the stimulus; each scenario checks the instance it targets.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [15:0] addr;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;

    logic        busy0, valid0, err0;
    logic [15:0] instr0;
    logic        busy1, valid1, err1;
    logic [15:0] instr1;
    logic        busy3, valid3, err3;
    logic [15:0] instr3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_w0 (
        .clk(clk), .reset(reset), .req(req), .addr(addr),
        .busy(busy0), .valid(valid0), .instr(instr0), .err(err0),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );
    imem_responder #(.DEPTH(256), .WAIT_STATES(1)) u_w1 (
        .clk(clk), .reset(reset), .req(req), .addr(addr),
        .busy(busy1), .valid(valid1), .instr(instr1), .err(err1),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );
    imem_responder #(.DEPTH(256), .WAIT_STATES(3)) u_w3 (
        .clk(clk), .reset(reset), .req(req), .addr(addr),
        .busy(busy3), .valid(valid3), .instr(instr3), .err(err3),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    // Memory is loaded while reset is held, which must still write.
    task automatic test_reset();
        reset = 1'b1; req = 1'b0; addr = 16'h0; prog_we = 1'b0; prog_addr = 8'h0; prog_data = 16'h0;
        tick();
        load(8'd0, 16'h1234);
        load(8'd3, 16'hA5C3);
        load(8'd5, 16'h1111);
        load(8'd7, 16'h7777);
        load(8'd9, 16'h9999);
        load(8'd255, 16'hBEEF);
        @(negedge clk);
        checks++; if ({busy0, busy1, busy3} !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b want 000", {busy0, busy1, busy3}); end
        checks++; if ({valid0, valid1, valid3, err0, err1, err3} !== 6'b0) begin errors++; $display("FAIL reset_valid_err: got %b want 000000", {valid0, valid1, valid3, err0, err1, err3}); end
        checks++; if (instr1 !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", instr1); end
        tick();
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_wait1();
        addr = 16'd3; req = 1'b1;
        @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL w1_busy_c0: got %b want 0", busy1); end
        tick(); req = 1'b0; addr = 16'd7;
        @(negedge clk);
        checks++; if ({busy1, valid1} !== 2'b10) begin errors++; $display("FAIL w1_c1 busy/valid: got %b want 10", {busy1, valid1}); end
        tick();
        @(negedge clk);
        checks++; if ({busy1, valid1, err1} !== 3'b110) begin errors++; $display("FAIL w1_c2 busy/valid/err: got %b want 110", {busy1, valid1, err1}); end
        checks++; if (instr1 !== 16'hA5C3) begin errors++; $display("FAIL w1_c2 instr: got %h want a5c3", instr1); end
        tick();
        @(negedge clk);
        checks++; if ({busy1, valid1} !== 2'b00) begin errors++; $display("FAIL w1_c3 busy/valid: got %b want 00", {busy1, valid1}); end
        checks++; if (instr1 !== 16'hA5C3) begin errors++; $display("FAIL w1_c3 instr hold: got %h want a5c3", instr1); end
        idle(6);
    endtask

    task automatic test_back_to_back();
        addr = 16'd0; req = 1'b1;
        tick();
        @(negedge clk);
        checks++; if ({valid0, err0} !== 2'b10 || instr0 !== 16'h1234) begin errors++; $display("FAIL w0_c1 valid/err/instr: got %b %h want 10 1234", {valid0, err0}, instr0); end
        tick();
        @(negedge clk);
        checks++; if ({busy0, valid0} !== 2'b00) begin errors++; $display("FAIL w0_c2 no accept in RESP: got busy/valid %b want 00", {busy0, valid0}); end
        tick(); req = 1'b0;
        @(negedge clk);
        checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL w0_c3 second valid: got %b want 1", valid0); end
        tick();
        @(negedge clk);
        checks++; if ({busy0, valid0} !== 2'b00) begin errors++; $display("FAIL w0_c4 idle: got %b want 00", {busy0, valid0}); end
        idle(6);
    endtask

    task automatic fetch_w1(input logic [15:0] a, output logic v, output logic e, output logic [15:0] d);
        addr = a; req = 1'b1;
        tick(); req = 1'b0;
        tick();
        @(negedge clk);
        v = valid1; e = err1; d = instr1;
        idle(6);
    endtask

    task automatic test_range();
        logic v, e;
        logic [15:0] d;
        fetch_w1(16'h0100, v, e, d);
        checks++; if ({v, e} !== 2'b11 || d !== 16'h0000) begin errors++; $display("FAIL oor_0100: got valid/err %b instr %h want 11 0000", {v, e}, d); end
        fetch_w1(16'h00FF, v, e, d);
        checks++; if ({v, e} !== 2'b10 || d !== 16'hBEEF) begin errors++; $display("FAIL inrange_00ff: got valid/err %b instr %h want 10 beef", {v, e}, d); end
        fetch_w1(16'hFFFF, v, e, d);
        checks++; if ({v, e} !== 2'b11 || d !== 16'h0000) begin errors++; $display("FAIL oor_ffff: got valid/err %b instr %h want 11 0000", {v, e}, d); end
    endtask

    task automatic test_read_before_write();
        logic v, e;
        logic [15:0] d;
        addr = 16'd5; req = 1'b1;
        tick(); req = 1'b0;
        prog_we = 1'b1; prog_addr = 8'd5; prog_data = 16'h2222;
        tick(); prog_we = 1'b0;
        @(negedge clk);
        checks++; if (valid1 !== 1'b1 || instr1 !== 16'h1111) begin errors++; $display("FAIL rbw_old: got valid %b instr %h want 1 1111", valid1, instr1); end
        idle(6);
        fetch_w1(16'd5, v, e, d);
        checks++; if (v !== 1'b1 || d !== 16'h2222) begin errors++; $display("FAIL rbw_refetch: got valid %b instr %h want 1 2222", v, d); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        addr = 16'd7; req = 1'b1;
        tick(); req = 1'b0;
        tick(); reset = 1'b1;
        @(negedge clk);
        checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b want 1", busy3); end
        tick(); reset = 1'b0;
        @(negedge clk);
        checks++; if ({busy3, valid3} !== 2'b00 || instr3 !== 16'h0000) begin errors++; $display("FAIL rst_mid_after: got busy/valid %b instr %h want 00 0000", {busy3, valid3}, instr3); end
        repeat (5) begin
            tick();
            @(negedge clk);
            if (valid3) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d pulses want 0", pulses); end
        addr = 16'd9; req = 1'b1;
        tick(); req = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++; if (valid3 !== 1'b0) begin errors++; $display("FAIL w3_c3 early valid: got %b want 0", valid3); end
        tick();
        @(negedge clk);
        checks++; if ({busy3, valid3, err3} !== 3'b110 || instr3 !== 16'h9999) begin errors++; $display("FAIL w3_c4: got b/v/e %b instr %h want 110 9999", {busy3, valid3, err3}, instr3); end
        idle(4);
    endtask

    task automatic test_ignore_busy();
        int pulses = 0;
        int at = -1;
        logic [15:0] got = 16'h0;
        addr = 16'd3; req = 1'b1;
        tick(); addr = 16'd7;
        @(negedge clk);
        checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL ign_busy_c1: got %b want 1", busy3); end
        tick(); req = 1'b0; addr = 16'd9;
        for (int c = 2; c <= 9; c++) begin
            @(negedge clk);
            if (valid3) begin pulses++; at = c; got = instr3; end
            tick();
        end
        checks++; if (pulses !== 1 || at !== 4) begin errors++; $display("FAIL ign_pulses: got %0d pulses at cycle %0d want 1 at 4", pulses, at); end
        checks++; if (got !== 16'hA5C3) begin errors++; $display("FAIL ign_instr: got %h want a5c3", got); end
    endtask

    task automatic test_mem_kept();
        logic v, e;
        logic [15:0] d;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        fetch_w1(16'd3, v, e, d);
        checks++; if ({v, e} !== 2'b10 || d !== 16'hA5C3) begin errors++; $display("FAIL mem_kept: got valid/err %b instr %h want 10 a5c3", {v, e}, d); end
    endtask

    initial begin
        test_reset();
        test_wait1();
        test_back_to_back();
        test_range();
        test_read_before_write();
        test_reset_mid();
        test_ignore_busy();
        test_mem_kept();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
